// File: rtl/foc_scheduler.sv
// foc_scheduler: per-PWM-period sequencer for the FOC chain (ADC..SVPWM, duty load).
// Optional stage watchdog: define FOC_SCHED_WATCHDOG_EN.
module foc_scheduler #(
    parameter int CNT_W      = 12,
    parameter int PWM_PERIOD = 2500,
    parameter int ADC_OFFSET = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iEn,
    input  logic             iFault_clr,
    input  logic             iADC_done,
    input  logic             iPark_done,
    input  logic             iPI_done,
    input  logic             iIPark_done,
    input  logic             iSVPWM_done,
    output logic             oADC_start,
    output logic             oPark_start,
    output logic             oPI_start,
    output logic             oIPark_start,
    output logic             oSVPWM_start,
    output logic             oDuty_load,
    output logic [CNT_W-1:0] oPWM_cnt,
    output logic             oBusy,
    output logic             oFault,
    output logic [7:0]       oOverrun_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_ADC, S_PARK, S_PI,
        S_IPARK, S_SVPWM, S_DONE, S_FAULT
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(PWM_PERIOD - 1);
    localparam logic [CNT_W-1:0] CntTrig = CNT_W'(ADC_OFFSET);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       start_q, start_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;
    logic [7:0]       ovr_q, ovr_d;
    logic             wrap, in_chain, done_sel, done_ok;

    assign wrap     = (cnt_q == CntLast);
    assign in_chain = (state_q == S_ADC) || (state_q == S_PARK) ||
                      (state_q == S_PI) || (state_q == S_IPARK) ||
                      (state_q == S_SVPWM);

    always_comb begin
        done_sel = 1'b0;
        case (state_q)
            S_ADC:   done_sel = iADC_done;
            S_PARK:  done_sel = iPark_done;
            S_PI:    done_sel = iPI_done;
            S_IPARK: done_sel = iIPark_done;
            S_SVPWM: done_sel = iSVPWM_done;
            default: done_sel = 1'b0;
        endcase
    end

    // a done coinciding with this stage's own start pulse is too early to trust
    assign done_ok = done_sel & ~(|start_q);

`ifdef FOC_SCHED_WATCHDOG_EN
    logic [7:0] tmr_q, tmr_d;
    logic       tmo;

    assign tmo = in_chain && !done_ok && (tmr_q == 8'(TIMEOUT - 1));
`else
    logic unused_clr;
    localparam int UnusedTimeout = TIMEOUT;

    assign unused_clr = iFault_clr;
`endif

    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        ovr_d   = ovr_q;
        cnt_d   = '0;
        if (iEn && !wrap) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // finishing SVPWM on the wrap cycle itself still counts as on time
        if (iEn && wrap && in_chain &&
            !(state_q == S_SVPWM && done_ok) && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            S_IDLE:  if (iEn) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == CntTrig) state_d = S_ADC;
            S_ADC:   if (done_ok) state_d = S_PARK;
            S_PARK:  if (done_ok) state_d = S_PI;
            S_PI:    if (done_ok) state_d = S_IPARK;
            S_IPARK: if (done_ok) state_d = S_SVPWM;
            S_SVPWM: if (done_ok) state_d = S_DONE;
            S_DONE: begin
                if (wrap) begin
                    state_d = S_WAIT;
                    load_d  = 1'b1;
                end
            end
            S_FAULT: begin
`ifdef FOC_SCHED_WATCHDOG_EN
                if (iFault_clr) state_d = iEn ? S_WAIT : S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

`ifdef FOC_SCHED_WATCHDOG_EN
        if (tmo) state_d = S_FAULT;
`endif

        if (!iEn && state_q != S_FAULT) begin
            state_d = S_IDLE;
            load_d  = 1'b0;
        end

        start_d[0] = (state_d == S_ADC)   && (state_q != S_ADC);
        start_d[1] = (state_d == S_PARK)  && (state_q != S_PARK);
        start_d[2] = (state_d == S_PI)    && (state_q != S_PI);
        start_d[3] = (state_d == S_IPARK) && (state_q != S_IPARK);
        start_d[4] = (state_d == S_SVPWM) && (state_q != S_SVPWM);
        busy_d     = (state_d == S_ADC) || (state_d == S_PARK) ||
                     (state_d == S_PI) || (state_d == S_IPARK) ||
                     (state_d == S_SVPWM);
        fault_d    = (state_d == S_FAULT);
    end

`ifdef FOC_SCHED_WATCHDOG_EN
    always_comb begin
        tmr_d = '0;
        if (state_d == state_q && tmr_q != 8'hFF) begin
            tmr_d = tmr_q + 8'd1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            start_q <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
            ovr_q   <= ovr_d;
        end
    end

    assign oADC_start   = start_q[0];
    assign oPark_start  = start_q[1];
    assign oPI_start    = start_q[2];
    assign oIPark_start = start_q[3];
    assign oSVPWM_start = start_q[4];
    assign oDuty_load   = load_q;
    assign oPWM_cnt     = cnt_q;
    assign oBusy        = busy_q;
    assign oOverrun_cnt = ovr_q;
`ifdef FOC_SCHED_WATCHDOG_EN
    assign oFault = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_q;
    assign oFault = 1'b0;
`endif

endmodule

// File: tb/tb_foc_scheduler.sv
// Scoreboard bench for foc_scheduler: expected start/load events are queued
// by the stimulus and popped by a monitor as the DUT pulses them.
module tb_foc_scheduler;

    localparam int CW = 12;
    localparam int PER = 100;
    localparam int OFF = 5;
    localparam int TO = 20;
`ifdef FOC_SCHED_WATCHDOG_EN
    localparam int WPO = 2;
`else
    localparam int WPO = 1;
`endif

    logic          iClk = 1'b0;
    logic          iRst_n = 1'b0;
    logic          iEn = 1'b0;
    logic          iFault_clr = 1'b0;
    logic [4:0]    done;
    logic          oADC_start, oPark_start, oPI_start;
    logic          oIPark_start, oSVPWM_start, oDuty_load;
    logic [CW-1:0] oPWM_cnt;
    logic          oBusy, oFault;
    logic [7:0]    oOverrun_cnt;
    logic [4:0]    st;
    logic [5:0]    ev;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    bit mon_en = 1'b1;
    bit spur_en = 1'b0;
    int dly[5];

    always #5 iClk = ~iClk;

    foc_scheduler #(
        .CNT_W(CW), .PWM_PERIOD(PER), .ADC_OFFSET(OFF), .TIMEOUT(TO)
    ) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iEn(iEn), .iFault_clr(iFault_clr),
        .iADC_done(done[0]), .iPark_done(done[1]), .iPI_done(done[2]),
        .iIPark_done(done[3]), .iSVPWM_done(done[4]),
        .oADC_start(oADC_start), .oPark_start(oPark_start),
        .oPI_start(oPI_start), .oIPark_start(oIPark_start),
        .oSVPWM_start(oSVPWM_start), .oDuty_load(oDuty_load),
        .oPWM_cnt(oPWM_cnt), .oBusy(oBusy), .oFault(oFault),
        .oOverrun_cnt(oOverrun_cnt)
    );

    assign st = {oSVPWM_start, oIPark_start, oPI_start, oPark_start, oADC_start};
    assign ev = {oDuty_load, st};

    // stage models: done pulses dly[i] cycles after start (0 = never)
    initial begin : model
        int cd[5];
        for (int i = 0; i < 5; i++) cd[i] = 0;
        done = '0;
        forever begin
            @(posedge iClk);
            #1;
            done = '0;
            for (int i = 0; i < 5; i++) begin
                if (cd[i] > 0) begin
                    cd[i] = cd[i] - 1;
                    if (cd[i] == 0) done[i] = 1'b1;
                end
                if (st[i]) cd[i] = dly[i];
            end
            if (spur_en && (st[1] || st[2])) done[1] = 1'b1;
        end
    end

    initial begin : monitor
        int got, want;
        forever begin
            @(negedge iClk);
            if (mon_en) begin
                for (int k = 0; k < 6; k++) begin
                    if (ev[k]) begin
                        got = k * 1000 + int'(oPWM_cnt);
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL event: got kind %0d at cnt %0d, required none",
                                     k, oPWM_cnt);
                        end else begin
                            want = exp_q.pop_front();
                            if (got != want) begin
                                errors++;
                                $display("FAIL event: got kind %0d at cnt %0d, required kind %0d at cnt %0d",
                                         k, oPWM_cnt, want / 1000, want % 1000);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic push_ev(input int k, input int c);
        exp_q.push_back(k * 1000 + c);
    endtask

    task automatic push_normal();
        push_ev(0, 6);
        push_ev(1, 10);
        push_ev(2, 14);
        push_ev(3, 18);
        push_ev(4, 22);
        push_ev(5, 0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge iClk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d events pending after %0d cycles, required 0",
                     name, exp_q.size(), bound);
            exp_q.delete();
        end
    endtask

    task automatic wait_cnt(input int v, input int bound, output bit ok);
        int n;
        n = 0;
        while (int'(oPWM_cnt) != v && n < bound) begin
            @(negedge iClk);
            n++;
        end
        ok = (int'(oPWM_cnt) == v);
    endtask

    initial begin : main
        bit ok;
        int n;
        for (int i = 0; i < 5; i++) dly[i] = 3;

        cyc(3);
        chk("rst_cnt", int'(oPWM_cnt), 0);
        chk("rst_outs", int'({ev, oBusy, oFault}), 0);
        chk("rst_ovr", int'(oOverrun_cnt), 0);
        iRst_n = 1'b1;
        cyc(2);
        chk("idle_cnt", int'(oPWM_cnt), 0);

        // normal period
        push_normal();
        iEn = 1'b1;
        wait_cnt(PER - 1, 200, ok);
        chk("reach_99", int'(ok), 1);
        @(negedge iClk);
        chk("wrap_0", int'(oPWM_cnt), 0);
        drain("normal", 200);
        chk("ovr_none", int'(oOverrun_cnt), 0);
        iEn = 1'b0;
        cyc(2);
        chk("dis_cnt", int'(oPWM_cnt), 0);
        chk("dis_busy", int'(oBusy), 0);

        // overrun: chain crosses the first wrap, loads at the second
`ifdef FOC_SCHED_WATCHDOG_EN
        for (int i = 0; i < 5; i++) dly[i] = 18;
        push_ev(0, 6);
        push_ev(1, 25);
        push_ev(2, 44);
        push_ev(3, 63);
        push_ev(4, 82);
        push_ev(5, 0);
`else
        dly[2] = 120;
        push_ev(0, 6);
        push_ev(1, 10);
        push_ev(2, 14);
        push_ev(3, 35);
        push_ev(4, 39);
        push_ev(5, 0);
`endif
        iEn = 1'b1;
        drain("overrun", 400);
        chk("ovr_one", int'(oOverrun_cnt), 1);
        iEn = 1'b0;
        for (int i = 0; i < 5; i++) dly[i] = 3;
        cyc(4);

        // spurious/early Park done
        spur_en = 1'b1;
        push_normal();
        iEn = 1'b1;
        drain("spurious", 300);
        spur_en = 1'b0;
        iEn = 1'b0;
        cyc(2);

        // enable dropped while in PI
        push_ev(0, 6);
        push_ev(1, 10);
        push_ev(2, 14);
        iEn = 1'b1;
        drain("pre_drop", 100);
        iEn = 1'b0;
        cyc(1);
        chk("drop_busy", int'(oBusy), 0);
        chk("drop_cnt", int'(oPWM_cnt), 0);
        cyc(10);
        chk("drop_ovr", int'(oOverrun_cnt), 1);
        push_normal();
        iEn = 1'b1;
        drain("reenable", 300);
        iEn = 1'b0;
        cyc(2);

        // Park never responds
        dly[1] = 0;
        push_ev(0, 6);
        push_ev(1, 10);
        iEn = 1'b1;
        drain("pre_hang", 100);
`ifdef FOC_SCHED_WATCHDOG_EN
        n = 0;
        while (!oFault && n < 40) begin
            cyc(1);
            n++;
        end
        chk("to_cycles", n, TO);
        chk("fault_busy", int'(oBusy), 0);
        cyc(110);
        chk("fault_sticky", int'(oFault), 1);
        dly[1] = 3;
        iFault_clr = 1'b1;
        cyc(1);
        iFault_clr = 1'b0;
        chk("fault_clr", int'(oFault), 0);
        push_normal();
        drain("after_clr", 300);
        chk("clr_ovr", int'(oOverrun_cnt), 1);
`else
        cyc(60);
        chk("nowd_fault", int'(oFault), 0);
        chk("nowd_busy", int'(oBusy), 1);
`endif
        iEn = 1'b0;
        dly[1] = 3;
        cyc(2);
        chk("hang_idle", int'(oBusy), 0);

        // saturation of the overrun counter
        mon_en = 1'b0;
`ifdef FOC_SCHED_WATCHDOG_EN
        for (int i = 0; i < 5; i++) dly[i] = 18;
`else
        dly[0] = 0;
`endif
        iEn = 1'b1;
        for (int w = 1; w <= 300 * WPO; w++) begin
            wait_cnt(PER - 1, 250, ok);
            if (!ok) begin
                chk("sat_wrap", 0, 1);
                break;
            end
            cyc(1);
            if (w == 100 * WPO) chk("ovr_mid", int'(oOverrun_cnt), 101);
        end
        chk("ovr_sat", int'(oOverrun_cnt), 255);
        iEn = 1'b0;
        cyc(3);
        chk("ovr_kept", int'(oOverrun_cnt), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
